seq_detector_param: RTL and testbench

- Parametrised successor of the team's fixed "101" serial detector: programmable pattern and length, overlap/non-overlap mode, saturating match counter.
- Runs on the single board clock. A clock-enable tick from an internal divider replaces the derived slow clock.
- Serial input x is sampled once per tick. Outputs drive an LED (y), a heartbeat LED and a status counter for the bring-up board.

---
 rtl/seq_detector_param.sv | 144 ++++++++++++++
 tb/tb_seq_detector_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial pattern detector with a programmable pattern, selectable
//   overlapping / non-overlapping matching and a saturating match counter.
//   An internal divider produces a one-clock sample strobe (tick); every
//   register updates on posedge clk, qualified by tick where needed.
//
// Parameters
//   DIV      board clocks per sample tick (>= 1)
//   PAT_LEN  pattern length in bits (>= 2)
//   PATTERN  pattern to detect, MSB = oldest bit, LSB = newest bit
//   CNT_W    width of the match counter
//
// Ports
//   clk         board system clock
//   rst_n       asynchronous active-low reset
//   x           serial data bit, sampled once per tick
//   overlap_en  1 = overlapping matches, 0 = non-overlapping (read on ticks)
//   clr_cnt     synchronous clear of match_cnt, wins over a same-clock match
//   y           registered match flag, held for one sample period
//   tick        one-clock sample strobe, period DIV clocks
//   heartbeat   toggles on every tick
//   match_cnt   saturating count of matches
//
// Build option
//   SEQ_DET_SYNC_EN  when defined, x passes through a 2-flop synchroniser
//                    before sampling; otherwise x must be synchronous to clk.
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int                 DIV     = 40000000,
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             y,
  output logic             tick,
  output logic             heartbeat,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W:0]   LEN_X    = (FILL_W + 1)'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [DIV_W-1:0]   div_q,  div_d;
  logic               tick_q, tick_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               y_q,    y_d;
  logic               hb_q,   hb_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic               x_s;
  logic [PAT_LEN-1:0] window;
  logic [FILL_W:0]    fill_inc;
  logic               match;

`ifdef SEQ_DET_SYNC_EN
  logic x_meta_q, x_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_meta_q <= 1'b0;
      x_sync_q <= 1'b0;
    end else begin
      x_meta_q <= x;
      x_sync_q <= x_meta_q;
    end
  end

  assign x_s = x_sync_q;
`else
  assign x_s = x;
`endif

  always_comb begin
    // tick is registered: it is raised on the same edge that loads DIV-1
    // into the divider, so tick==1 exactly while div_q==DIV-1.
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);

    window   = {hist_q, x_s};
    // fill counts bits already in the history; +1 accounts for the bit
    // being sampled now.
    fill_inc = {1'b0, fill_q} + (FILL_W + 1)'(1);
    match    = tick_q && (window == PATTERN) && (fill_inc >= LEN_X);

    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = y_q;
    hb_d   = hb_q;
    if (tick_q) begin
      hist_d = window[PAT_LEN-2:0];
      hb_d   = ~hb_q;
      y_d    = match;
      if (match && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      hb_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      hb_q   <= hb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y         = y_q;
  assign tick      = tick_q;
  assign heartbeat = hb_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed bench for seq_detector_param with DIV=4, PAT_LEN=3, PATTERN=101.
//   A second instance with CNT_W=2 shares the stimulus and covers counter
//   saturation.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int         DIV     = 4;
  localparam int         PAT_LEN = 3;
  localparam logic [2:0] PATTERN = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x = 1'b0;
  logic       overlap_en = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       y, tick, heartbeat;
  logic [7:0] match_cnt;
  logic       y2, tick2, hb2;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .DIV(DIV), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .x(x), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .y(y), .tick(tick), .heartbeat(heartbeat),
    .match_cnt(match_cnt)
  );

  seq_detector_param #(
    .DIV(DIV), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .y(y2), .tick(tick2), .heartbeat(hb2),
    .match_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Ends on a falling edge with rst_n just released (clk 1 after release).
  task automatic do_reset(input logic ov);
    rst_n      = 1'b0;
    x          = 1'b0;
    clr_cnt    = 1'b0;
    overlap_en = ov;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one sample, waits for the tick that takes it, and returns 1ns
  // after the sampling edge so y/match_cnt reflect this sample.
  task automatic send(input logic b);
    int n;
    x = b;
    n = 0;
    @(negedge clk);
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tick) chk("tick_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int smp[11]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int y_ov[7]  = '{0, 0, 1, 0, 1, 0, 1};
  int y_nov[7] = '{0, 0, 1, 0, 0, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;

    // Reset state, tick spacing and heartbeat
    do_reset(1'b1);
    chk("rst_y", y, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_hb", heartbeat, 0);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("tick_clk%0d", k + 1), tick, ((k + 1) % DIV == 0));
      chk($sformatf("hb_clk%0d", k + 1), heartbeat, ticks % 2);
      if ((k + 1) % DIV == 0) ticks++;
    end

    // Overlapping matches on 1010101
    do_reset(1'b1);
    for (int i = 0; i < 7; i++) begin
      send(smp[i][0]);
      chk($sformatf("ov_y%0d", i + 1), y, y_ov[i]);
    end
    chk("ov_cnt", match_cnt, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("ov_y_hold", y, 1);

    // Non-overlapping matches on 1010101
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      send(smp[i][0]);
      chk($sformatf("nov_y%0d", i + 1), y, y_nov[i]);
    end
    chk("nov_cnt", match_cnt, 2);

    // Saturation: 5 matches into a 2-bit counter
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      send(smp[i][0]);
      if (i == 6) chk("sat_cnt2_at3", cnt2, 3);
    end
    chk("sat_cnt2_final", cnt2, 3);
    chk("sat_cnt8_final", match_cnt, 5);

    // Counter clear
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send(smp[i][0]);
    chk("clr_pre", match_cnt, 2);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr_after_match", match_cnt, 0);
    send(1'b0);
    send(1'b1);
    chk("clr_recount", match_cnt, 1);
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr_no_match", match_cnt, 0);
    send(1'b0);
    clr_cnt = 1'b1;
    send(1'b1);
    clr_cnt = 1'b0;
    chk("clr_prio_y", y, 1);
    chk("clr_prio_cnt", match_cnt, 0);
    send(1'b0);
    send(1'b1);
    chk("clr_post_prio", match_cnt, 1);

    // Reset mid-stream discards partial history
    do_reset(1'b1);
    send(1'b1);
    send(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", y, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_cnt", match_cnt, 0);
    send(1'b1);
    chk("mid_y1", y, 0);
    send(1'b0);
    chk("mid_y2", y, 0);
    send(1'b1);
    chk("mid_y3", y, 1);
    chk("mid_cnt", match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
